// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register feeding the main decoder.
// Handles stall, redirect (branch/jump flush) and a clean stop on the halt opcode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = 6'b111111
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] if_id_instr_o,
  output logic [31:0] if_id_pc4_o,
  output logic        if_id_valid_o,
  output logic [5:0]  instr_op_o,
  output logic        halted_o,
  output logic [31:0] fetch_cnt_o
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic [31:0]  redirect_target;

  assign pc_plus4        = pc + 32'd4;
  assign redirect_target = {redirect_pc_i[31:2], 2'b00};

  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the same pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= FETCH;
      pc            <= RESET_PC;
      if_id_instr_o <= 32'h0;
      if_id_pc4_o   <= 32'h0;
      if_id_valid_o <= 1'b0;
      halted_o      <= 1'b0;
      fetch_cnt_o   <= 32'h0;
    end else begin
      unique case (state)
        FETCH, DRAIN: begin
          if (redirect_i) begin
            // Redirect beats stall; the wrong-path slot becomes a bubble.
            pc            <= redirect_target;
            if_id_instr_o <= 32'h0;
            if_id_pc4_o   <= 32'h0;
            if_id_valid_o <= 1'b0;
            state         <= FETCH;
          end else if (!stall_i) begin
            if (state == FETCH) begin
              pc            <= pc_plus4;
              if_id_instr_o <= imem_data_i;
              if_id_pc4_o   <= pc_plus4;
              if_id_valid_o <= 1'b1;
              fetch_cnt_o   <= fetch_cnt_o + 32'd1;
              if (imem_data_i[31:26] == HALT_OP) begin
                state <= DRAIN;
              end
            end else begin
              // Halt leaves IF/ID; pc4 is kept so the last PC stays visible.
              if_id_instr_o <= 32'h0;
              if_id_valid_o <= 1'b0;
              halted_o      <= 1'b1;
              state         <= HALTED;
            end
          end
        end
        default: begin
          // HALTED: frozen until reset.
        end
      endcase
    end
  end

  assign imem_addr_o = pc;
  assign instr_op_o  = if_id_instr_o[31:26];

endmodule
